// File: rtl/idex_operand_stage_if.sv
// idex_operand_stage_if: ID-stage fields, MEM/WB forward sources and EX-stage outputs of the ID/EX stage.
// Revision 1.0
`default_nettype none

interface idex_operand_stage_if #(
  parameter int WIDTH = 32
);
  // ID-stage instruction fields
  logic             id_valid_i;
  logic [WIDTH-1:0] id_pc_i;
  logic [WIDTH-1:0] id_rs1_data_i;
  logic [WIDTH-1:0] id_rs2_data_i;
  logic [WIDTH-1:0] id_imm_i;
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic [4:0]       id_rd_i;
  logic             id_uses_rs1_i;
  logic             id_uses_rs2_i;
  logic [3:0]       id_alu_ctrl_i;
  logic             id_alu_src_a_i;
  logic             id_alu_src_b_i;
  logic             id_reg_write_i;
  logic             id_mem_read_i;
  logic             id_mem_write_i;

  // Forward sources (EX/MEM and MEM/WB) and redirect
  logic             mem_reg_write_i;
  logic [4:0]       mem_rd_i;
  logic [WIDTH-1:0] mem_result_i;
  logic             wb_reg_write_i;
  logic [4:0]       wb_rd_i;
  logic [WIDTH-1:0] wb_result_i;
  logic             flush_i;

  // EX-stage outputs
  logic             load_use_stall_o;
  logic             ex_valid_o;
  logic [WIDTH-1:0] ex_a_o;
  logic [WIDTH-1:0] ex_b_o;
  logic [3:0]       ex_alu_ctrl_o;
  logic [WIDTH-1:0] ex_store_data_o;
  logic [WIDTH-1:0] ex_pc_o;
  logic [4:0]       ex_rd_o;
  logic             ex_reg_write_o;
  logic             ex_mem_read_o;
  logic             ex_mem_write_o;

  modport master (
    output id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_uses_rs1_i, id_uses_rs2_i,
           id_alu_ctrl_i, id_alu_src_a_i, id_alu_src_b_i,
           id_reg_write_i, id_mem_read_i, id_mem_write_i,
           mem_reg_write_i, mem_rd_i, mem_result_i,
           wb_reg_write_i, wb_rd_i, wb_result_i, flush_i,
    input  load_use_stall_o, ex_valid_o, ex_a_o, ex_b_o, ex_alu_ctrl_o,
           ex_store_data_o, ex_pc_o, ex_rd_o,
           ex_reg_write_o, ex_mem_read_o, ex_mem_write_o
  );

  modport slave (
    input  id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_uses_rs1_i, id_uses_rs2_i,
           id_alu_ctrl_i, id_alu_src_a_i, id_alu_src_b_i,
           id_reg_write_i, id_mem_read_i, id_mem_write_i,
           mem_reg_write_i, mem_rd_i, mem_result_i,
           wb_reg_write_i, wb_rd_i, wb_result_i, flush_i,
    output load_use_stall_o, ex_valid_o, ex_a_o, ex_b_o, ex_alu_ctrl_o,
           ex_store_data_o, ex_pc_o, ex_rd_o,
           ex_reg_write_o, ex_mem_read_o, ex_mem_write_o
  );
endinterface

`default_nettype wire

// File: rtl/idex_operand_stage.sv
// idex_operand_stage: ID/EX pipeline register with write-through capture, MEM/WB forwarding and load-use bubbles.
// Revision 1.0
`default_nettype none

module idex_operand_stage #(
  parameter int WIDTH = 32
) (
  input  wire logic          clk,
  input  wire logic          reset,
  idex_operand_stage_if.slave bus
);

  localparam logic [4:0] c_x0 = 5'd0;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] pc;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [WIDTH-1:0] imm;
    logic [4:0]       rd;
    logic [3:0]       alu_ctrl;
    logic             src_a;
    logic             src_b;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
  } idex_t;

  idex_t            idex_q;
  idex_t            idex_d;

  logic             w_stall;
  logic             w_wt_rs1;
  logic             w_wt_rs2;
  logic [WIDTH-1:0] w_fwd1;
  logic [WIDTH-1:0] w_fwd2;

  // A load in EX whose destination the ID instruction reads; a dead (flushed) ID never stalls.
  assign w_stall = idex_q.valid && idex_q.mem_read && (idex_q.rd != c_x0) &&
                   bus.id_valid_i && !bus.flush_i &&
                   ((bus.id_uses_rs1_i && (bus.id_rs1_i == idex_q.rd)) ||
                    (bus.id_uses_rs2_i && (bus.id_rs2_i == idex_q.rd)));

  // The register file does not bypass its own same-cycle write, so catch it here.
  assign w_wt_rs1 = bus.wb_reg_write_i && (bus.wb_rd_i == bus.id_rs1_i) && (bus.id_rs1_i != c_x0);
  assign w_wt_rs2 = bus.wb_reg_write_i && (bus.wb_rd_i == bus.id_rs2_i) && (bus.id_rs2_i != c_x0);

  always_comb begin
    idex_d = '0;
    if (!bus.flush_i && !w_stall) begin
      idex_d.valid    = bus.id_valid_i;
      idex_d.pc       = bus.id_pc_i;
      idex_d.rs1      = bus.id_rs1_i;
      idex_d.rs2      = bus.id_rs2_i;
      idex_d.rs1_val  = w_wt_rs1 ? bus.wb_result_i : bus.id_rs1_data_i;
      idex_d.rs2_val  = w_wt_rs2 ? bus.wb_result_i : bus.id_rs2_data_i;
      idex_d.imm      = bus.id_imm_i;
      idex_d.rd       = bus.id_rd_i;
      idex_d.alu_ctrl = bus.id_alu_ctrl_i;
      idex_d.src_a    = bus.id_alu_src_a_i;
      idex_d.src_b    = bus.id_alu_src_b_i;
      if (bus.id_valid_i) begin
        idex_d.reg_write = bus.id_reg_write_i;
        idex_d.mem_read  = bus.id_mem_read_i;
        idex_d.mem_write = bus.id_mem_write_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    w_fwd1 = idex_q.rs1_val;
    if (bus.mem_reg_write_i && (bus.mem_rd_i != c_x0) && (bus.mem_rd_i == idex_q.rs1)) begin
      w_fwd1 = bus.mem_result_i;
    end else if (bus.wb_reg_write_i && (bus.wb_rd_i != c_x0) && (bus.wb_rd_i == idex_q.rs1)) begin
      w_fwd1 = bus.wb_result_i;
    end
  end

  always_comb begin
    w_fwd2 = idex_q.rs2_val;
    if (bus.mem_reg_write_i && (bus.mem_rd_i != c_x0) && (bus.mem_rd_i == idex_q.rs2)) begin
      w_fwd2 = bus.mem_result_i;
    end else if (bus.wb_reg_write_i && (bus.wb_rd_i != c_x0) && (bus.wb_rd_i == idex_q.rs2)) begin
      w_fwd2 = bus.wb_result_i;
    end
  end

  assign bus.load_use_stall_o = w_stall;
  assign bus.ex_valid_o       = idex_q.valid;
  assign bus.ex_a_o           = idex_q.src_a ? idex_q.pc  : w_fwd1;
  assign bus.ex_b_o           = idex_q.src_b ? idex_q.imm : w_fwd2;
  assign bus.ex_alu_ctrl_o    = idex_q.alu_ctrl;
  assign bus.ex_store_data_o  = w_fwd2;
  assign bus.ex_pc_o          = idex_q.pc;
  assign bus.ex_rd_o          = idex_q.rd;
  assign bus.ex_reg_write_o   = idex_q.reg_write;
  assign bus.ex_mem_read_o    = idex_q.mem_read;
  assign bus.ex_mem_write_o   = idex_q.mem_write;

endmodule

`default_nettype wire
